// File: rtl/ahb_slave_pkg.sv
// ahb_slave_pkg: shared AHB transfer encodings and the data-phase response states.
package ahb_slave_pkg;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;
    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    typedef enum logic [1:0] {OKAY, ERR1, ERR2} resp_state_t;
endpackage

// File: rtl/ahb_lane_mask.sv
// ahb_lane_mask: byte enables and misalignment flag for a transfer size and low address bits.
module ahb_lane_mask
    import ahb_slave_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr,
    output logic [3:0] be,
    output logic       misalign
);
    always_comb begin
        be       = (size == HSIZE_BYTE) ? 4'b0001 << addr :
                   (size == HSIZE_HALF) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        misalign = (size == HSIZE_HALF && addr[0]) || (size == HSIZE_WORD && addr != 2'b00);
    end
endmodule

// File: rtl/ahb_slave_data_phase.sv
// ahb_slave_data_phase: AHB data-phase stage with a small word-addressed register file.
// Define AHB_SLV_ERR_EN to answer bad transfers with the two-cycle ERROR response.
module ahb_slave_data_phase
    import ahb_slave_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DATA_W-1:0] hwdata,
    output logic [DATA_W-1:0] hrdata,
    output logic              hready,
    output logic              hresp
);
`ifdef AHB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int IW = $clog2(NUM_REGS);

    resp_state_t       state;
    logic [IW-1:0]     a_idx;
    logic              a_write, a_bad;
    logic [3:0]        a_be, be;
    logic              misalign, sample, bad_now, commit;
    logic [DATA_W-1:0] regs [NUM_REGS];

    ahb_lane_mask u_lane_mask (.size(hsize), .addr(haddr[1:0]), .be(be), .misalign(misalign));

    assign sample  = hsel && hready && (htrans == HTRANS_NSEQ || htrans == HTRANS_SEQ);
    assign bad_now = (haddr[ADDR_W-1:2] >= (ADDR_W-2)'(NUM_REGS)) || (hsize > HSIZE_WORD) || misalign;
    assign commit  = state == OKAY && enable && a_write && !a_bad;
    assign hready  = state != ERR1;
    assign hresp   = ERR_EN && state != OKAY;
    assign hrdata  = (enable && !a_write && !a_bad) ? regs[a_idx] : '0;

    // Lane enables are captured with the address so the commit never sees the next transfer's size.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OKAY;
            a_idx   <= '0;
            a_write <= 1'b0;
            a_be    <= '0;
            a_bad   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (sample) begin
                a_idx   <= haddr[IW+1:2];
                a_write <= hwrite;
                a_be    <= be;
                a_bad   <= bad_now;
            end
            if (commit)
                for (int b = 0; b < 4; b++)
                    if (a_be[b]) regs[a_idx][8*b +: 8] <= hwdata[8*b +: 8];
            state <= (state == ERR1) ? ERR2 :
                     (state == OKAY && ERR_EN && enable && a_bad) ? ERR1 : OKAY;
        end
    end
endmodule

// File: tb/tb_ahb_slave_data_phase.sv
// tb_ahb_slave_data_phase: randomized self-checking bench against a register-file reference model.
module tb_ahb_slave_data_phase;
    import ahb_slave_pkg::*;
`ifdef AHB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst, enable, hsel, hwrite, hready, hresp;
    logic [1:0]  htrans;
    logic [7:0]  haddr;
    logic [2:0]  hsize;
    logic [31:0] hwdata, hrdata;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mregs [4];

    always #5 clk = ~clk;

    ahb_slave_data_phase dut (
        .clk(clk), .rst(rst), .enable(enable), .hsel(hsel), .htrans(htrans),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = HTRANS_IDLE; enable = 1'b0; hwrite = 1'b0;
        haddr = '0; hsize = '0; hwdata = '0;
    endtask

    function automatic bit is_bad(input logic [7:0] a, input logic [2:0] s);
        return (int'(a) / 4 >= 4) || (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [7:0] a, input logic [2:0] s);
        logic [31:0] m;
        m = (s == 3'd0) ? 32'hFF << (8 * int'(a[1:0])) :
            (s == 3'd1) ? 32'hFFFF << (a[1] ? 16 : 0) : 32'hFFFF_FFFF;
        return (old & ~m) | (d & m);
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [2:0] s, input logic [31:0] d);
        if (!is_bad(a, s)) mregs[int'(a) / 4] = merge(mregs[int'(a) / 4], d, a, s);
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a, input logic [2:0] s);
        return is_bad(a, s) ? 32'h0 : mregs[int'(a) / 4];
    endfunction

    function automatic logic [5:0] exp_trace(input logic [7:0] a, input logic [2:0] s);
        return (ERR_EN && is_bad(a, s)) ? 6'b10_01_11 : 6'b10_10_10;
    endfunction

    // One isolated transfer: address phase, data phase, then two trailing cycles of hready/hresp.
    task automatic xfer(input logic [7:0] a, input logic w, input logic [2:0] s, input logic [31:0] d,
                        output logic [31:0] rd, output logic [5:0] tr);
        hsel = 1'b1; htrans = HTRANS_NSEQ; haddr = a; hwrite = w; hsize = s; enable = 1'b0;
        step();
        hsel = 1'b0; htrans = HTRANS_IDLE; enable = 1'b1; hwdata = d;
        #1; rd = hrdata; tr[5:4] = {hready, hresp};
        step();
        enable = 1'b0;
        #1; tr[3:2] = {hready, hresp};
        step();
        #1; tr[1:0] = {hready, hresp};
        step();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [5:0]  tr;
        bus_idle(); rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (hready !== 1'b1) begin failures++; $display("FAIL reset_hready got=%b exp=1", hready); end
        checks++; if (hresp !== 1'b0) begin failures++; $display("FAIL reset_hresp got=%b exp=0", hresp); end
        checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=0", hrdata); end
        for (int i = 0; i < 4; i++) mregs[i] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            xfer(8'(4 * i), 1'b0, HSIZE_WORD, 32'h0, rd, tr);
            checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_read%0d got=%h exp=0", i, rd); end
        end
    endtask

    task automatic test_word_b2b();
        hsel = 1'b1; htrans = HTRANS_NSEQ; haddr = 8'h04; hwrite = 1'b1; hsize = HSIZE_WORD;
        step();
        enable = 1'b1; hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
        #1;
        checks++; if (hready !== 1'b1) begin failures++; $display("FAIL b2b_wr_hready got=%b exp=1", hready); end
        model_write(8'h04, HSIZE_WORD, 32'hDEAD_BEEF);
        step();
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h0;
        #1;
        checks++; if (hrdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_rd_data got=%h exp=deadbeef", hrdata); end
        checks++; if (hrdata !== model_read(8'h04, HSIZE_WORD)) begin failures++; $display("FAIL b2b_rd_model got=%h exp=%h", hrdata, model_read(8'h04, HSIZE_WORD)); end
        checks++; if (hready !== 1'b1) begin failures++; $display("FAIL b2b_rd_hready got=%b exp=1", hready); end
        step();
        bus_idle();
    endtask

    task automatic test_byte_half();
        logic [31:0] rd;
        logic [5:0]  tr;
        xfer(8'h00, 1'b1, HSIZE_WORD, 32'h1122_3344, rd, tr); model_write(8'h00, HSIZE_WORD, 32'h1122_3344);
        xfer(8'h02, 1'b1, HSIZE_BYTE, 32'h00AA_0000, rd, tr); model_write(8'h02, HSIZE_BYTE, 32'h00AA_0000);
        xfer(8'h00, 1'b0, HSIZE_WORD, 32'h0, rd, tr);
        checks++; if (rd !== 32'h11AA_3344) begin failures++; $display("FAIL byte_write got=%h exp=11aa3344", rd); end
        xfer(8'h00, 1'b1, HSIZE_HALF, 32'h0000_BBCC, rd, tr); model_write(8'h00, HSIZE_HALF, 32'h0000_BBCC);
        xfer(8'h00, 1'b0, HSIZE_WORD, 32'h0, rd, tr);
        checks++; if (rd !== 32'h11AA_BBCC) begin failures++; $display("FAIL half_write got=%h exp=11aabbcc", rd); end
        checks++; if (rd !== mregs[0]) begin failures++; $display("FAIL half_model got=%h exp=%h", rd, mregs[0]); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic [5:0]  tr;
        xfer(8'h10, 1'b1, HSIZE_WORD, 32'h5555_5555, rd, tr);
        checks++; if (tr !== exp_trace(8'h10, HSIZE_WORD)) begin failures++; $display("FAIL oor_resp got=%b exp=%b", tr, exp_trace(8'h10, HSIZE_WORD)); end
        for (int i = 0; i < 4; i++) begin
            xfer(8'(4 * i), 1'b0, HSIZE_WORD, 32'h0, rd, tr);
            checks++; if (rd !== mregs[i]) begin failures++; $display("FAIL oor_unchanged%0d got=%h exp=%h", i, rd, mregs[i]); end
        end
    endtask

    task automatic test_misaligned();
        hsel = 1'b1; htrans = HTRANS_NSEQ; haddr = 8'h02; hwrite = 1'b0; hsize = HSIZE_WORD;
        step();
        hsel = 1'b0; htrans = HTRANS_IDLE; enable = 1'b1;
        #1;
        checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL mis_hrdata got=%h exp=0", hrdata); end
        checks++; if ({hready, hresp} !== 2'b10) begin failures++; $display("FAIL mis_dphase got=%b exp=10", {hready, hresp}); end
        step();
        enable = 1'b0;
        #1;
        checks++; if ({hready, hresp} !== (ERR_EN ? 2'b01 : 2'b10)) begin failures++; $display("FAIL mis_err1 got=%b exp=%b", {hready, hresp}, ERR_EN ? 2'b01 : 2'b10); end
        step();
        hsel = 1'b1; htrans = HTRANS_NSEQ; haddr = 8'h04; hsize = HSIZE_WORD;
        #1;
        checks++; if ({hready, hresp} !== (ERR_EN ? 2'b11 : 2'b10)) begin failures++; $display("FAIL mis_err2 got=%b exp=%b", {hready, hresp}, ERR_EN ? 2'b11 : 2'b10); end
        step();
        hsel = 1'b0; htrans = HTRANS_IDLE; enable = 1'b1;
        #1;
        checks++; if ({hready, hresp} !== 2'b10) begin failures++; $display("FAIL mis_next_resp got=%b exp=10", {hready, hresp}); end
        checks++; if (hrdata !== mregs[1]) begin failures++; $display("FAIL mis_next_data got=%h exp=%h", hrdata, mregs[1]); end
        step();
        bus_idle();
    endtask

    task automatic test_busy_idle();
        logic [31:0] rd;
        logic [5:0]  tr;
        xfer(8'h04, 1'b1, HSIZE_WORD, 32'h1111_0001, rd, tr); model_write(8'h04, HSIZE_WORD, 32'h1111_0001);
        xfer(8'h08, 1'b1, HSIZE_WORD, 32'h2222_0002, rd, tr); model_write(8'h08, HSIZE_WORD, 32'h2222_0002);
        hsel = 1'b1; htrans = HTRANS_NSEQ; haddr = 8'h04; hwrite = 1'b0; hsize = HSIZE_WORD;
        step();
        htrans = HTRANS_BUSY; haddr = 8'h08; enable = 1'b1;
        #1;
        checks++; if (hrdata !== mregs[1]) begin failures++; $display("FAIL busy_first got=%h exp=%h", hrdata, mregs[1]); end
        step();
        htrans = HTRANS_IDLE; hwrite = 1'b1;
        #1;
        checks++; if (hrdata !== mregs[1]) begin failures++; $display("FAIL busy_hold got=%h exp=%h", hrdata, mregs[1]); end
        step();
        hsel = 1'b0;
        #1;
        checks++; if (hrdata !== mregs[1]) begin failures++; $display("FAIL idle_hold got=%h exp=%h", hrdata, mregs[1]); end
        step();
        bus_idle();
    endtask

    task automatic test_random();
        logic [31:0] rd, d;
        logic [7:0]  a;
        logic [2:0]  s;
        logic [5:0]  tr;
        logic        w;
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom_range(0, 23));
            s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            xfer(a, w, s, d, rd, tr);
            checks++; if (rd !== (w ? 32'h0 : model_read(a, s))) begin failures++; $display("FAIL rand_data n=%0d a=%h s=%0d w=%b got=%h exp=%h", n, a, s, w, rd, w ? 32'h0 : model_read(a, s)); end
            checks++; if (tr !== exp_trace(a, s)) begin failures++; $display("FAIL rand_resp n=%0d a=%h s=%0d got=%b exp=%b", n, a, s, tr, exp_trace(a, s)); end
            if (w) model_write(a, s, d);
        end
    endtask

    // Fully pipelined legal stream: each cycle carries one address phase and the previous data phase.
    task automatic test_back_to_back();
        logic [7:0]  a [31];
        logic [2:0]  s [31];
        logic        w [31];
        logic [31:0] d [31];
        logic [31:0] exp;
        for (int n = 0; n < 30; n++) begin
            s[n] = 3'($urandom_range(0, 2));
            a[n] = 8'(4 * $urandom_range(0, 3) + (s[n] == 3'd0 ? $urandom_range(0, 3) : s[n] == 3'd1 ? 2 * $urandom_range(0, 1) : 0));
            w[n] = 1'($urandom_range(0, 1));
            d[n] = $urandom;
        end
        for (int n = 0; n <= 30; n++) begin
            hsel = n < 30; htrans = (n < 30) ? HTRANS_SEQ : HTRANS_IDLE;
            if (n < 30) begin haddr = a[n]; hwrite = w[n]; hsize = s[n]; end
            enable = n > 0;
            if (n > 0) begin
                hwdata = d[n-1];
                #1;
                exp = w[n-1] ? 32'h0 : model_read(a[n-1], s[n-1]);
                checks++; if (hrdata !== exp) begin failures++; $display("FAIL b2b_rand_data n=%0d got=%h exp=%h", n - 1, hrdata, exp); end
                checks++; if ({hready, hresp} !== 2'b10) begin failures++; $display("FAIL b2b_rand_resp n=%0d got=%b exp=10", n - 1, {hready, hresp}); end
                if (w[n-1]) model_write(a[n-1], s[n-1], d[n-1]);
            end
            step();
        end
        bus_idle();
    endtask

    task automatic test_reset_mid_error();
        logic [31:0] rd;
        logic [5:0]  tr;
        xfer(8'h0C, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, rd, tr); model_write(8'h0C, HSIZE_WORD, 32'hCAFE_F00D);
        hsel = 1'b1; htrans = HTRANS_NSEQ; haddr = 8'h10; hwrite = 1'b1; hsize = HSIZE_WORD;
        step();
        hsel = 1'b0; htrans = HTRANS_IDLE; enable = 1'b1; hwdata = 32'h1234_5678;
        step();
        enable = 1'b0;
        #1;
        checks++; if ({hready, hresp} !== (ERR_EN ? 2'b01 : 2'b10)) begin failures++; $display("FAIL rst_err1 got=%b exp=%b", {hready, hresp}, ERR_EN ? 2'b01 : 2'b10); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if ({hready, hresp} !== 2'b10) begin failures++; $display("FAIL rst_mid_resp got=%b exp=10", {hready, hresp}); end
        for (int i = 0; i < 4; i++) mregs[i] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            xfer(8'(4 * i), 1'b0, HSIZE_WORD, 32'h0, rd, tr);
            checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_mid_reg%0d got=%h exp=0", i, rd); end
        end
    endtask

    initial begin
        test_reset();
        test_word_b2b();
        test_byte_half();
        test_out_of_range();
        test_misaligned();
        test_busy_idle();
        test_random();
        test_back_to_back();
        test_reset_mid_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
